// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants, read-mode enum and pointer-width helper
// for the parametrised synchronous FIFO family.
package fifo_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 16;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } rd_mode_e;

    // Pointers carry one extra wrap bit beyond the RAM address.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: DEPTH x DATA_W simple dual-port RAM, one write port and
// one registered read port; contents are not reset so a vendor macro fits.
module fifo_sdp_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with level, threshold flags
// and sticky errors; define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ptr_w(DEPTH)-1:0]  level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

`ifdef SYNC_FIFO_FWFT_EN
    localparam rd_mode_e MODE = FWFT;
`else
    localparam rd_mode_e MODE = STD;
`endif

    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic              valid_q, valid_d;
    logic              seen_q, seen_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic              wr_acc;
    logic              rd_acc;
    logic              ram_re;
    logic [PW-1:0]     ram_cnt;
    logic [DATA_W-1:0] ram_q;

    // Words sitting in the RAM, not counting the FWFT output word.
    assign ram_cnt = wptr_q - rptr_q;

    always_comb begin
        full   = (level_q == PW'(DEPTH));
`ifdef SYNC_FIFO_FWFT_EN
        empty  = !valid_q;
`else
        empty  = (level_q == '0);
`endif
        wr_acc = wr_en && !full;
        rd_acc = rd_en && !empty;
    end

    always_comb begin
`ifdef SYNC_FIFO_FWFT_EN
        // Refill the output word whenever it is free or being consumed.
        ram_re  = (ram_cnt != '0) && (!valid_q || rd_acc);
        valid_d = ram_re || (valid_q && !rd_acc);
`else
        ram_re  = rd_acc;
        valid_d = rd_acc;
`endif
        wptr_d  = wptr_q + PW'(wr_acc);
        rptr_d  = rptr_q + PW'(ram_re);
        level_d = level_q + PW'(wr_acc) - PW'(rd_acc);
        seen_d  = seen_q || ram_re;
        ovf_d   = ovf_q || (wr_en && full);
        udf_d   = udf_q || (rd_en && empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (ram_q)
    );

    // RAM read register is not reset, so mask it until a word was fetched.
    assign rd_data      = seen_q ? ram_q : '0;
    assign rd_valid     = valid_q;
    assign level        = level_q;
    assign almost_full  = (level_q >= PW'(AFULL_TH));
    assign almost_empty = (level_q <= PW'(AEMPTY_TH));
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    a_level_ptrs: assert property (@(posedge clk) disable iff (rst)
        level_q == ram_cnt + ((MODE == FWFT) ? PW'(valid_q) : '0));

    a_fwft_valid: assert property (@(posedge clk) disable iff (rst)
        (MODE == FWFT) |-> (rd_valid == !empty));

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: table vectors, directed corner sequences and a
// queue-based reference model under random traffic.
module tb_sync_fifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int LW    = 5;

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FW = 1'b1;
`else
    localparam bit FW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic [15:0] d;
        int          lvl;
        logic        emp;
        logic        ae;
        logic        rv;
        logic [15:0] rdat;
    } vec_t;

    vec_t tbl[10];

    // Reference model: queue of held words plus visible-head bookkeeping.
    logic [15:0] mq[$];
    bit          m_ovf, m_udf, m_rv, m_shown;
    logic [15:0] m_last;

    task automatic mreset();
        mq.delete();
        m_ovf   = 0;
        m_udf   = 0;
        m_rv    = 0;
        m_shown = 0;
        m_last  = '0;
    endtask

    task automatic mstep(input logic w, input logic r, input logic [15:0] d);
        bit mfull, memp, racc, wacc;
        mfull = (mq.size() == DEPTH);
        memp  = FW ? !m_shown : (mq.size() == 0);
        if (w && mfull) m_ovf = 1;
        if (r && memp) m_udf = 1;
        racc = r && !memp;
        wacc = w && !mfull;
        if (FW) begin
            if (racc) begin
                void'(mq.pop_front());
                m_shown = 0;
            end
            if (!m_shown && mq.size() > 0) begin
                m_shown = 1;
                m_last  = mq[0];
            end
        end else begin
            m_rv = racc;
            if (racc) m_last = mq.pop_front();
        end
        if (wacc) mq.push_back(d);
    endtask

    function automatic logic [31:0] mvec();
        int   n;
        logic rv;
        logic emp;
        n   = mq.size();
        rv  = FW ? m_shown : m_rv;
        emp = FW ? !m_shown : (n == 0);
        return {4'd0, LW'(n), (n == DEPTH), emp, (n >= AF), (n <= AE),
                rv, m_ovf, m_udf, m_last};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [15:0] d);
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        mreset();
    endtask

    task automatic fill16();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 16'(i));
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        if (FW) begin
            tbl[0] = '{1, 0, 100, 1, 1, 1, 0, 0};
            tbl[1] = '{1, 0, 101, 2, 0, 1, 1, 100};
            tbl[2] = '{1, 0, 102, 3, 0, 0, 1, 100};
            tbl[3] = '{1, 0, 103, 4, 0, 0, 1, 100};
            tbl[4] = '{0, 1, 0, 3, 0, 0, 1, 101};
            tbl[5] = '{0, 1, 0, 2, 0, 1, 1, 102};
            tbl[6] = '{0, 1, 0, 1, 0, 1, 1, 103};
            tbl[7] = '{0, 1, 0, 0, 1, 1, 0, 103};
            tbl[8] = '{0, 0, 0, 0, 1, 1, 0, 103};
            tbl[9] = '{0, 0, 0, 0, 1, 1, 0, 103};
        end else begin
            tbl[0] = '{1, 0, 100, 1, 0, 1, 0, 0};
            tbl[1] = '{1, 0, 101, 2, 0, 1, 0, 0};
            tbl[2] = '{1, 0, 102, 3, 0, 0, 0, 0};
            tbl[3] = '{1, 0, 103, 4, 0, 0, 0, 0};
            tbl[4] = '{0, 0, 0, 4, 0, 0, 0, 0};
            tbl[5] = '{0, 1, 0, 3, 0, 0, 1, 100};
            tbl[6] = '{0, 1, 0, 2, 0, 1, 1, 101};
            tbl[7] = '{0, 1, 0, 1, 0, 1, 1, 102};
            tbl[8] = '{0, 1, 0, 0, 1, 1, 1, 103};
            tbl[9] = '{0, 0, 0, 0, 1, 1, 0, 103};
        end

        do_reset();
        chk("rst_vec", {level, full, almost_full, empty, almost_empty,
                        rd_valid, overflow, underflow, rd_data},
            {5'd0, 7'b0011000, 16'd0});

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].w, tbl[i].r, tbl[i].d);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            chk($sformatf("tbl%0d_aempty", i), 32'(almost_empty),
                32'(tbl[i].ae));
            chk($sformatf("tbl%0d_rvalid", i), 32'(rd_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdata", i), 32'(rd_data), 32'(tbl[i].rdat));
        end
        chk("tbl_no_udf", 32'(underflow), 32'd0);

        if (!FW) begin
            // Fill to full, then one dropped write.
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                cyc(1'b1, 1'b0, 16'(i));
                chk($sformatf("fill%0d_afull", i), 32'(almost_full),
                    32'(i + 1 >= AF));
                chk($sformatf("fill%0d_full", i), 32'(full),
                    32'(i + 1 == DEPTH));
            end
            cyc(1'b1, 1'b0, 16'hdead);
            chk("ovf_level", 32'(level), 32'd16);
            chk("ovf_flag", 32'(overflow), 32'd1);
            for (int i = 0; i < DEPTH; i++) begin
                cyc(1'b0, 1'b1, 16'd0);
                chk($sformatf("drain%0d", i), {15'd0, rd_valid, rd_data},
                    {15'd0, 1'b1, 16'(i)});
            end
            chk("drain_empty", 32'(empty), 32'd1);

            // Full with both requests: read only.
            do_reset();
            fill16();
            cyc(1'b1, 1'b1, 16'h0055);
            chk("fullboth_level", 32'(level), 32'd15);
            chk("fullboth_ovf", 32'(overflow), 32'd1);
            chk("fullboth_rdata", 32'(rd_data), 32'd0);

            // Empty with both requests: write only.
            do_reset();
            cyc(1'b1, 1'b1, 16'h00ab);
            chk("emptyboth_level", 32'(level), 32'd1);
            chk("emptyboth_udf", 32'(underflow), 32'd1);
            chk("emptyboth_rv", 32'(rd_valid), 32'd0);
            cyc(1'b0, 1'b1, 16'd0);
            chk("emptyboth_rd", {15'd0, rd_valid, rd_data},
                {15'd0, 1'b1, 16'h00ab});

            // Steady stream at level 8 across several pointer wraps.
            do_reset();
            for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 16'(i));
            for (int k = 0; k < 40; k++) begin
                cyc(1'b1, 1'b1, 16'(k + 8));
                chk($sformatf("stream%0d", k), {level, 10'd0, rd_valid,
                    rd_data}, {5'd8, 10'd0, 1'b1, 16'(k)});
            end

            // Reset mid-operation overrides concurrent requests.
            do_reset();
            fill16();
            cyc(1'b1, 1'b0, 16'hbeef);
            for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 16'd0);
            chk("pre_rst_level", 32'(level), 32'd9);
            @(negedge clk);
            rst     = 1'b1;
            wr_en   = 1'b1;
            rd_en   = 1'b1;
            wr_data = 16'h1234;
            @(posedge clk);
            #1;
            chk("midrst", {level, empty, overflow, rd_valid, rd_data},
                {5'd0, 3'b100, 16'd0});
            @(negedge clk);
            rst   = 1'b0;
            wr_en = 1'b0;
            rd_en = 1'b0;
        end

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic w, r;
            logic [15:0] d;
            int pw;
            pw = ((i / 150) % 2 == 0) ? 70 : 30;
            w  = ($urandom_range(99, 0) < pw);
            r  = ($urandom_range(99, 0) < (100 - pw));
            d  = 16'($urandom);
            cyc(w, r, d);
            mstep(w, r, d);
            chk($sformatf("rand%0d", i),
                {4'd0, level, full, empty, almost_full, almost_empty,
                 rd_valid, overflow, underflow, rd_data}, mvec());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
